mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory command port between two load requesters (rd0 = K/V prefetcher, rd1 = Q prefetcher) and one store requester (O drain).
- Round-robin arbitration across the three requesters.
- Tracks outstanding load tags and routes returned blocks back to the requester that issued them.
- Reports port idle so the top-level sequencer can change phases safely.

Parameters:
- NUM_RD: default 2; number of load requesters (ids 0..NUM_RD-1).
- MAX_OUTSTANDING: default `NUM_MEM_TAGS; maximum loads in flight; further loads are stalled.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_vld  in  NUM_RD  per-requester load request
- rd_req_addr  in  NUM_RD x ADDR  load address per requester
- rd_req_rdy  out  NUM_RD  load accepted this cycle
- rd_rsp_vld  out  1  returned block valid
- rd_rsp_id  out  $clog2(NUM_RD)  requester id that owns rd_rsp_data
- rd_rsp_data  out  MEM_BLOCK  returned block
- wr_req_vld  in  1  store request
- wr_req_addr  in  ADDR  store address
- wr_req_data  in  MEM_BLOCK  store data
- wr_req_rdy  out  1  store accepted this cycle
- mem2proc_transaction_tag  in  MEM_TAG  tag for this cycle's command; 0 = rejected
- mem2proc_data  in  MEM_BLOCK  returned data
- mem2proc_data_tag  in  MEM_TAG  tag of returned data; 0 = none
- proc2mem_command  out  MEM_COMMAND  NONE/LOAD/STORE
- proc2mem_addr  out  ADDR  command address
- proc2mem_data  out  MEM_BLOCK  store data
- idle  out  1  no requests and no outstanding loads
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0, async):
  - rr_ptr=0, all tag-table entries invalid, outstanding count=0, err=0.
  - rd_rsp_vld=0, rd_rsp_id=0, rd_rsp_data=0.
  - Combinational outputs evaluate to command NONE, addr 0, data 0, all rdy=0, idle=1.
- Eligibility:
  - rd[i] is eligible when rd_req_vld[i]=1 and count < MAX_OUTSTANDING.
  - wr is eligible when wr_req_vld=1.
- Arbitration:
  - Order of requesters: rd0, rd1, ..., wr (NUM_RD+1 slots).
  - Grant goes to the first eligible slot at or after rr_ptr, wrapping.
  - Grant is combinational in the same cycle.
  - proc2mem_command/addr/data are driven from the granted slot.
  - proc2mem_data is 0 for a load.
  - With no grant: command NONE, addr 0, data 0.
- Acceptance:
  - A transfer is accepted when a grant exists and mem2proc_transaction_tag != 0.
  - The granted rdy is 1 only on acceptance; requesters must hold vld/addr/data until rdy.
  - On acceptance, rr_ptr <= granted slot + 1 (wrapping).
  - On rejection, rr_ptr holds; the same grant repeats next cycle if requests are unchanged.
- Load issue: on an accepted load with tag T, set table[T] = {valid=1, id=i} and increment count.
  - If table[T] is already valid, err <= 1 and the entry is overwritten.
- Return: when mem2proc_data_tag = T != 0 and table[T] is valid:
  - next cycle rd_rsp_vld=1, rd_rsp_id=table[T].id, rd_rsp_data=mem2proc_data (1-cycle registered latency);
  - clear table[T]; decrement count.
  - Responses cannot be backpressured; requesters reserve space before requesting.
- Unmatched return: nonzero data tag with invalid entry → dropped, err <= 1. This includes returns for loads issued before a reset.
- Simultaneous issue and return in one cycle:
  - The return is processed first, then the issue.
  - Same tag T on both: entry ends valid with the new id, and no err.
  - Count is unchanged (+1-1).
- Stores allocate no table entry and produce no response.
- Count never exceeds MAX_OUTSTANDING. At full, loads stall but stores still proceed.
- idle = (count==0) && !(|rd_req_vld) && !wr_req_vld. idle is combinational.

Decomposition:
- Shared package (sys_defs), shared with other blocks: MEM_TAG, MEM_BLOCK, MEM_COMMAND, ADDR, `NUM_MEM_TAGS.
- Add to sys_defs:
  - ARB_SLOT_T: slot index type, width $clog2(NUM_RD+1);
  - TAG_ENTRY_T: struct {valid, id}.
- Sub-module: tag_tracker. It holds the table indexed by MEM_TAG, the outstanding count, the registered response path and err. The top level holds the round-robin arbiter and the port mux.

Test Plan:
- Single load: rd0 vld, addr 0x1000, memory returns tag 3 → command LOAD, addr 0x1000, rd_req_rdy=01. Data tag 3 with 0xAA..AA returns 4 cycles later → next cycle rd_rsp_vld=1, id=0, data 0xAA..AA, idle=1 afterwards.
- Fairness: rd0, rd1 and wr all held valid, every command accepted → grants rd0, rd1, wr, rd0, rd1, wr over 6 cycles.
- Rejection: wr vld, transaction tag 0 for 2 cycles then 5 → wr_req_rdy=0, 0, 1; rr_ptr unchanged until acceptance; command STORE on all 3 cycles.
- Full stall: MAX_OUTSTANDING=2; rd0 issues tags 1 and 2, no returns → rd0 stalled and a concurrent wr is granted. Tag 1 returns → rd0 issues on the following cycle.
- Simultaneous issue and return: tag 4 returns for rd1 in the same cycle that rd0 issues and memory gives tag 4 → response id=1, table[4].id=0, count unchanged, err=0.
- Reset mid-flight: rst_n low with 3 loads outstanding → outputs at reset values, idle=1. Later return of tag 2 → no response, err=1.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs: memory-port types shared across blocks, plus the arbiter slot and tag-table types
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
package sys_defs;
    localparam int NUM_MEM_TAGS = `NUM_MEM_TAGS;
    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;
    localparam int ARB_NUM_RD = 2;
    typedef logic [$clog2(ARB_NUM_RD+1)-1:0] ARB_SLOT_T;
    typedef logic [$clog2(ARB_NUM_RD)-1:0] ARB_ID_T;
    typedef struct packed {
        logic    valid;
        ARB_ID_T id;
    } TAG_ENTRY_T;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side load/store handshakes and the load response path
interface mem_port_arbiter_if #(parameter int NUM_RD = sys_defs::ARB_NUM_RD);
    import sys_defs::*;
    logic [NUM_RD-1:0]         rd_req_vld;
    ADDR  [NUM_RD-1:0]         rd_req_addr;
    logic [NUM_RD-1:0]         rd_req_rdy;
    logic                      rd_rsp_vld;
    logic [$clog2(NUM_RD)-1:0] rd_rsp_id;
    MEM_BLOCK                  rd_rsp_data;
    logic                      wr_req_vld;
    ADDR                       wr_req_addr;
    MEM_BLOCK                  wr_req_data;
    logic                      wr_req_rdy;
    modport master (
        output rd_req_vld, rd_req_addr, wr_req_vld, wr_req_addr, wr_req_data,
        input  rd_req_rdy, rd_rsp_vld, rd_rsp_id, rd_rsp_data, wr_req_rdy
    );
    modport slave (
        input  rd_req_vld, rd_req_addr, wr_req_vld, wr_req_addr, wr_req_data,
        output rd_req_rdy, rd_rsp_vld, rd_rsp_id, rd_rsp_data, wr_req_rdy
    );
endinterface

// File: rtl/mem_port_arbiter_tag_tracker.sv
// tag_tracker: outstanding-load table indexed by memory tag, in-flight count,
// registered response routing and the sticky protocol error flag
module tag_tracker
    import sys_defs::*;
#(
    parameter int MAX_OUTSTANDING = NUM_MEM_TAGS,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issue,
    input  MEM_TAG   issue_tag,
    input  ARB_ID_T  issue_id,
    input  MEM_TAG   ret_tag,
    input  MEM_BLOCK ret_data,
    output logic     full,
    output logic     empty,
    output logic     rsp_vld,
    output ARB_ID_T  rsp_id,
    output MEM_BLOCK rsp_data,
    output logic     err
);
    localparam int NT = 2 ** $bits(MEM_TAG);
    TAG_ENTRY_T    tags_q [NT];
    TAG_ENTRY_T    ret_ent;
    logic [CW-1:0] count;
    logic          ret_hit, ret_miss, clash;
    assign ret_ent  = tags_q[ret_tag];
    assign ret_hit  = ret_tag != '0 && ret_ent.valid;
    assign ret_miss = ret_tag != '0 && !ret_ent.valid;
    // a return on the same tag frees the entry first, so reusing it is legal
    assign clash = issue && tags_q[issue_tag].valid && !(ret_hit && ret_tag == issue_tag);
    assign full  = count >= CW'(MAX_OUTSTANDING);
    assign empty = count == '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) tags_q[i] <= '0;
            count    <= '0;
            rsp_vld  <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
            err      <= 1'b0;
        end else begin
            if (ret_hit) tags_q[ret_tag].valid <= 1'b0;
            if (issue) tags_q[issue_tag] <= '{valid: 1'b1, id: issue_id};
            count    <= count + CW'(issue) - CW'(ret_hit);
            rsp_vld  <= ret_hit;
            rsp_id   <= ret_hit ? ret_ent.id : '0;
            rsp_data <= ret_hit ? ret_data : '0;
            err      <= err | ret_miss | clash;
        end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the memory command port between NUM_RD
// load requesters and one store requester, with tag-based load response routing
module mem_port_arbiter
    import sys_defs::*;
#(
    parameter int NUM_RD          = ARB_NUM_RD,
    parameter int MAX_OUTSTANDING = `NUM_MEM_TAGS
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    input  MEM_TAG             mem2proc_transaction_tag,
    input  MEM_BLOCK           mem2proc_data,
    input  MEM_TAG             mem2proc_data_tag,
    output MEM_COMMAND         proc2mem_command,
    output ADDR                proc2mem_addr,
    output MEM_BLOCK           proc2mem_data,
    output logic               idle,
    output logic               err
);
    localparam int SLOTS = NUM_RD + 1;
    localparam int IW = $clog2(NUM_RD);
    localparam ARB_SLOT_T WR_SLOT = ARB_SLOT_T'(NUM_RD);
    ARB_SLOT_T        rr_ptr, gnt;
    logic             gnt_vld, accept, is_wr, full, empty;
    logic [SLOTS-1:0] elig;
    function automatic ARB_SLOT_T slot_at(input ARB_SLOT_T p, input int k);
        int s;
        s = int'(p) + k;
        return ARB_SLOT_T'(s >= SLOTS ? s - SLOTS : s);
    endfunction
    assign elig = {bus.wr_req_vld, bus.rd_req_vld & {NUM_RD{!full}}};
    // first eligible slot at or after rr_ptr, wrapping
    always_comb begin
        gnt     = rr_ptr;
        gnt_vld = 1'b0;
        for (int k = 0; k < SLOTS; k++)
            if (!gnt_vld && elig[slot_at(rr_ptr, k)]) begin
                gnt     = slot_at(rr_ptr, k);
                gnt_vld = 1'b1;
            end
    end
    assign accept           = gnt_vld && mem2proc_transaction_tag != '0;
    assign is_wr            = gnt == WR_SLOT;
    assign proc2mem_command = !gnt_vld ? MEM_NONE : is_wr ? MEM_STORE : MEM_LOAD;
    assign proc2mem_addr    = !gnt_vld ? '0 : is_wr ? bus.wr_req_addr : bus.rd_req_addr[gnt[IW-1:0]];
    assign proc2mem_data    = gnt_vld && is_wr ? bus.wr_req_data : '0;
    assign bus.wr_req_rdy   = accept && is_wr;
    always_comb begin
        bus.rd_req_rdy = '0;
        for (int i = 0; i < NUM_RD; i++) bus.rd_req_rdy[i] = accept && gnt == ARB_SLOT_T'(i);
    end
    assign idle = empty && !(|bus.rd_req_vld) && !bus.wr_req_vld;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rr_ptr <= '0;
        else if (accept) rr_ptr <= is_wr ? '0 : gnt + 1'b1;
    tag_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (accept && !is_wr),
        .issue_tag (mem2proc_transaction_tag),
        .issue_id  (gnt[IW-1:0]),
        .ret_tag   (mem2proc_data_tag),
        .ret_data  (mem2proc_data),
        .full      (full),
        .empty     (empty),
        .rsp_vld   (bus.rd_rsp_vld),
        .rsp_id    (bus.rd_rsp_id),
        .rsp_data  (bus.rd_rsp_data),
        .err       (err)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expected commands/responses checked by a monitor
module tb_mem_port_arbiter;
    import sys_defs::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.NUM_RD(2)) bus ();
    mem_port_arbiter_if #(.NUM_RD(2)) bus2 ();
    MEM_TAG     tag, dtag, tag2, dtag2;
    MEM_BLOCK   mdata, mdata2, pdata, pdata2;
    MEM_COMMAND cmd, cmd2;
    ADDR        addr, addr2;
    logic       idle, err, idle2, err2;
    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem2proc_transaction_tag(tag), .mem2proc_data(mdata), .mem2proc_data_tag(dtag),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(pdata),
        .idle(idle), .err(err)
    );
    mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .mem2proc_transaction_tag(tag2), .mem2proc_data(mdata2), .mem2proc_data_tag(dtag2),
        .proc2mem_command(cmd2), .proc2mem_addr(addr2), .proc2mem_data(pdata2),
        .idle(idle2), .err(err2)
    );
    typedef struct packed {
        MEM_COMMAND c;
        ADDR        a;
        MEM_BLOCK   d;
        logic [1:0] rd_rdy;
        logic       wr_rdy;
    } cmd_t;
    typedef struct packed {
        logic     id;
        MEM_BLOCK d;
    } rsp_t;
    cmd_t cq[$], cq2[$];
    rsp_t rq[$], rq2[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, exp);
        end
    endtask
    task automatic cmp_cmd(input string n, input cmd_t a, input cmd_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got cmd=%0d addr=%h data=%h rd_rdy=%b wr_rdy=%b exp cmd=%0d addr=%h data=%h rd_rdy=%b wr_rdy=%b",
                     n, a.c, a.a, a.d, a.rd_rdy, a.wr_rdy, e.c, e.a, e.d, e.rd_rdy, e.wr_rdy);
        end
    endtask
    task automatic cmp_rsp(input string n, input rsp_t a, input rsp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got id=%0d data=%h exp id=%0d data=%h", n, a.id, a.d, e.id, e.d);
        end
    endtask
    always @(negedge clk) begin
        cmd_t e;
        rsp_t r;
        if (cmd != MEM_NONE) begin
            e = '0;
            if (cq.size() > 0) e = cq.pop_front();
            cmp_cmd("dut_cmd", '{cmd, addr, pdata, bus.rd_req_rdy, bus.wr_req_rdy}, e);
        end
        if (bus.rd_rsp_vld) begin
            r = '0;
            if (rq.size() > 0) r = rq.pop_front();
            cmp_rsp("dut_rsp", '{bus.rd_rsp_id, bus.rd_rsp_data}, r);
        end
        if (cmd2 != MEM_NONE) begin
            e = '0;
            if (cq2.size() > 0) e = cq2.pop_front();
            cmp_cmd("dut2_cmd", '{cmd2, addr2, pdata2, bus2.rd_req_rdy, bus2.wr_req_rdy}, e);
        end
        if (bus2.rd_rsp_vld) begin
            r = '0;
            if (rq2.size() > 0) r = rq2.pop_front();
            cmp_rsp("dut2_rsp", '{bus2.rd_rsp_id, bus2.rd_rsp_data}, r);
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        MEM_TAG ftag [6] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
        bus.rd_req_vld = '0; bus.rd_req_addr = '0;
        bus.wr_req_vld = 1'b0; bus.wr_req_addr = '0; bus.wr_req_data = '0;
        bus2.rd_req_vld = '0; bus2.rd_req_addr = '0;
        bus2.wr_req_vld = 1'b0; bus2.wr_req_addr = '0; bus2.wr_req_data = '0;
        tag = '0; dtag = '0; mdata = '0; tag2 = '0; dtag2 = '0; mdata2 = '0;
        #12;
        chk("reset_idle", idle, 1);
        chk("reset_err", err, 0);
        chk("reset_cmd", cmd, MEM_NONE);
        chk("reset_rsp_vld", bus.rd_rsp_vld, 0);
        chk("reset_rsp_id", bus.rd_rsp_id, 0);
        chk("reset_rsp_data", bus.rd_rsp_data, 0);
        cyc();
        rst_n = 1'b1;
        // single load from rd0, data back four cycles later
        bus.rd_req_vld = 2'b01; bus.rd_req_addr[0] = 32'h1000; tag = 4'd3;
        cq.push_back(cmd_t'{MEM_LOAD, 32'h1000, 64'h0, 2'b01, 1'b0});
        cyc();
        bus.rd_req_vld = '0; tag = '0;
        chk("load_idle_busy", idle, 0);
        cyc(); cyc(); cyc();
        dtag = 4'd3; mdata = 64'hAAAA_AAAA_AAAA_AAAA;
        rq.push_back(rsp_t'{1'b0, 64'hAAAA_AAAA_AAAA_AAAA});
        cyc();
        dtag = '0;
        chk("load_idle_after", idle, 1);
        // store rejected twice, then accepted
        bus.wr_req_vld = 1'b1; bus.wr_req_addr = 32'h2000; bus.wr_req_data = 64'h5555_5555_5555_5555;
        tag = '0;
        cq.push_back(cmd_t'{MEM_STORE, 32'h2000, 64'h5555_5555_5555_5555, 2'b00, 1'b0});
        cyc();
        cq.push_back(cmd_t'{MEM_STORE, 32'h2000, 64'h5555_5555_5555_5555, 2'b00, 1'b0});
        cyc();
        tag = 4'd5;
        cq.push_back(cmd_t'{MEM_STORE, 32'h2000, 64'h5555_5555_5555_5555, 2'b00, 1'b1});
        cyc();
        // all three requesters held, every command accepted
        bus.rd_req_vld = 2'b11; bus.rd_req_addr[0] = 32'h1100; bus.rd_req_addr[1] = 32'h1200;
        for (int k = 0; k < 6; k++) begin
            tag = ftag[k];
            if (k % 3 == 0) cq.push_back(cmd_t'{MEM_LOAD, 32'h1100, 64'h0, 2'b01, 1'b0});
            if (k % 3 == 1) cq.push_back(cmd_t'{MEM_LOAD, 32'h1200, 64'h0, 2'b10, 1'b0});
            if (k % 3 == 2) cq.push_back(cmd_t'{MEM_STORE, 32'h2000, 64'h5555_5555_5555_5555, 2'b00, 1'b1});
            cyc();
        end
        bus.rd_req_vld = '0; bus.wr_req_vld = 1'b0; tag = '0;
        dtag = 4'd9; mdata = 64'h9999_9999_9999_9999;
        rq.push_back(rsp_t'{1'b1, 64'h9999_9999_9999_9999});
        cyc();
        dtag = 4'd1; mdata = 64'h1111_1111_1111_1111;
        rq.push_back(rsp_t'{1'b0, 64'h1111_1111_1111_1111});
        cyc();
        dtag = '0;
        // tag 4 issued for rd1, then returned while rd0 reissues on tag 4
        bus.rd_req_vld = 2'b10; bus.rd_req_addr[1] = 32'h1400; tag = 4'd4;
        cq.push_back(cmd_t'{MEM_LOAD, 32'h1400, 64'h0, 2'b10, 1'b0});
        cyc();
        bus.rd_req_vld = 2'b01; bus.rd_req_addr[0] = 32'h1500; tag = 4'd4;
        dtag = 4'd4; mdata = 64'h4444_4444_4444_4444;
        cq.push_back(cmd_t'{MEM_LOAD, 32'h1500, 64'h0, 2'b01, 1'b0});
        rq.push_back(rsp_t'{1'b1, 64'h4444_4444_4444_4444});
        cyc();
        bus.rd_req_vld = '0; tag = '0; dtag = '0;
        chk("simul_err", err, 0);
        chk("simul_count", 64'(dut.u_trk.count), 3);
        cyc();
        dtag = 4'd4; mdata = 64'h4B4B_4B4B_4B4B_4B4B;
        rq.push_back(rsp_t'{1'b0, 64'h4B4B_4B4B_4B4B_4B4B});
        cyc();
        dtag = '0;
        chk("reuse_err", err, 0);
        bus.rd_req_vld = 2'b01; bus.rd_req_addr[0] = 32'h1600; tag = 4'd6;
        cq.push_back(cmd_t'{MEM_LOAD, 32'h1600, 64'h0, 2'b01, 1'b0});
        cyc();
        bus.rd_req_vld = '0; tag = '0;
        dtag = 4'd12; mdata = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        dtag = '0;
        chk("unmatched_err", err, 1);
        chk("pre_reset_count", 64'(dut.u_trk.count), 3);
        chk("pre_reset_idle", idle, 0);
        // reset with three loads in flight
        rst_n = 1'b0;
        #2;
        chk("midrst_idle", idle, 1);
        chk("midrst_err", err, 0);
        chk("midrst_cmd", cmd, MEM_NONE);
        chk("midrst_rsp_vld", bus.rd_rsp_vld, 0);
        chk("midrst_count", 64'(dut.u_trk.count), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        dtag = 4'd2; mdata = 64'h2222_2222_2222_2222;
        cyc();
        dtag = '0;
        chk("stale_rsp_vld", bus.rd_rsp_vld, 0);
        chk("stale_err", err, 1);
        chk("stale_idle", idle, 1);
        // full stall on the two-deep instance
        bus2.rd_req_vld = 2'b01; bus2.rd_req_addr[0] = 32'h3000; tag2 = 4'd1;
        cq2.push_back(cmd_t'{MEM_LOAD, 32'h3000, 64'h0, 2'b01, 1'b0});
        cyc();
        tag2 = 4'd2;
        cq2.push_back(cmd_t'{MEM_LOAD, 32'h3000, 64'h0, 2'b01, 1'b0});
        cyc();
        bus2.wr_req_vld = 1'b1; bus2.wr_req_addr = 32'h3800; bus2.wr_req_data = 64'h7777_7777_7777_7777;
        tag2 = 4'd3;
        cq2.push_back(cmd_t'{MEM_STORE, 32'h3800, 64'h7777_7777_7777_7777, 2'b00, 1'b1});
        cyc();
        bus2.wr_req_vld = 1'b0; tag2 = 4'd4;
        dtag2 = 4'd1; mdata2 = 64'h1111_1111_1111_1111;
        rq2.push_back(rsp_t'{1'b0, 64'h1111_1111_1111_1111});
        #1;
        chk("stall_cmd", cmd2, MEM_NONE);
        chk("stall_rdy", bus2.rd_req_rdy, 0);
        cyc();
        dtag2 = '0;
        cq2.push_back(cmd_t'{MEM_LOAD, 32'h3000, 64'h0, 2'b01, 1'b0});
        cyc();
        bus2.rd_req_vld = '0; tag2 = '0;
        cyc(); cyc();
        chk("stall_err", err2, 0);
        chk("stall_idle", idle2, 0);
        chk("cq_drained", cq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("cq2_drained", cq2.size(), 0);
        chk("rq2_drained", rq2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
